// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment decoder/reader pair: segment patterns
// ({g,f,e,d,c,b,a}, a = bit 0, active-high), decoded codes and reader FSM states.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_ALL   = 7'h7F;
    localparam logic [6:0] SEG_HORIZ = 7'h49;
    localparam logic [6:0] SEG_MID   = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_HORIZ   = 4'hA;
    localparam logic [3:0] CODE_MID     = 4'hB;
    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_UNKNOWN = 4'hF;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } rd_state_t;

endpackage

// File: rtl/seven_seg_pattern_to_code.sv
// Combinational lookup from an active-high segment pattern to its 4-bit code;
// patterns outside the table decode to CODE_UNKNOWN.
module seven_seg_pattern_to_code
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = CODE_UNKNOWN;
        case (pattern_i)
            SEG_0:     code_o = 4'h0;
            SEG_1:     code_o = 4'h1;
            SEG_2:     code_o = 4'h2;
            SEG_3:     code_o = 4'h3;
            SEG_4:     code_o = 4'h4;
            SEG_5:     code_o = 4'h5;
            SEG_6:     code_o = 4'h6;
            SEG_7:     code_o = 4'h7;
            SEG_8:     code_o = 4'h8;
            SEG_9:     code_o = 4'h9;
            SEG_HORIZ: code_o = CODE_HORIZ;
            SEG_MID:   code_o = CODE_MID;
            SEG_BLANK: code_o = CODE_BLANK;
            default:   code_o = CODE_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Multiplexed seven-segment bus reader: debounces {sel, pattern} and stores the decoded
// code per display position. Define SEVEN_SEG_READER_DP_EN to add dp_in/dp_out.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   sel_in,
    input  logic                    common_cathode,
    input  logic                    clr_err,
`ifdef SEVEN_SEG_READER_DP_EN
    input  logic                    dp_in,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] digit_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    new_pulse,
    output logic                    sel_err
);

`ifdef SEVEN_SEG_READER_DP_EN
    localparam int unsigned KEY_W = NUM_DIGITS + 8;
`else
    localparam int unsigned KEY_W = NUM_DIGITS + 7;
`endif
    localparam logic [CNT_W-1:0] STABLE_L = CNT_W'(STABLE_CYCLES);

    logic [6:0]              seg_s_q;
    logic [NUM_DIGITS-1:0]   sel_s_q;
    logic [KEY_W-1:0]        prev_q;
    rd_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    pulse_q;
    logic                    err_q, err_d;

    logic [6:0]              pat;
    logic [3:0]              code;
    logic [KEY_W-1:0]        key;
    logic                    multi_hot, one_hot, same, commit;

`ifdef SEVEN_SEG_READER_DP_EN
    logic                    dp_s_q;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   dpo_q, dpo_d;

    // Polarity is applied after the sample stage so a live common_cathode change
    // shows up as a key change on the very next compare.
    assign dp_n = common_cathode ? dp_s_q : ~dp_s_q;
    assign key  = {sel_s_q, pat, dp_n};
`else
    assign key  = {sel_s_q, pat};
`endif

    assign pat       = common_cathode ? seg_s_q : ~seg_s_q;
    assign multi_hot = |(sel_s_q & (sel_s_q - NUM_DIGITS'(1)));
    assign one_hot   = (sel_s_q != '0) && !multi_hot;
    assign same      = (key == prev_q);

    seven_seg_pattern_to_code u_decode (
        .pattern_i (pat),
        .code_o    (code)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (one_hot) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!one_hot) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (same) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!one_hot) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Commit on the same edge the count lands on the threshold, so a
        // threshold of 1 commits straight out of IDLE or HOLD.
        if (state_d == ST_SETTLE && cnt_d == STABLE_L) begin
            commit  = 1'b1;
            state_d = ST_HOLD;
        end
    end

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
`ifdef SEVEN_SEG_READER_DP_EN
        dpo_d   = dpo_q;
`endif
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (commit && sel_s_q[i]) begin
                digit_d[4*i +: 4] = code;
                valid_d[i]        = 1'b1;
`ifdef SEVEN_SEG_READER_DP_EN
                dpo_d[i]          = dp_n;
`endif
            end
        end
        err_d = err_q;
        if (multi_hot) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_s_q <= '0;
            sel_s_q <= '0;
            prev_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            digit_q <= '0;
            valid_q <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
            dp_s_q  <= 1'b0;
            dpo_q   <= '0;
`endif
        end else if (ena) begin
            seg_s_q <= seg_in;
            sel_s_q <= sel_in;
            prev_q  <= key;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            pulse_q <= commit;
            err_q   <= err_d;
`ifdef SEVEN_SEG_READER_DP_EN
            dp_s_q  <= dp_in;
            dpo_q   <= dpo_d;
`endif
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign new_pulse   = pulse_q & ena;
    assign sel_err     = err_q;
`ifdef SEVEN_SEG_READER_DP_EN
    assign dp_out      = dpo_q;
`endif

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: two instances (threshold 4 and 1) against a
// run-length reference model, plus directed corner-case sequences.
module tb_seven_seg_reader;

    logic        clk = 1'b0;
    logic        rst_n, ena, cc, clr_err;
    logic [6:0]  seg_in;
    logic [3:0]  sel_in;
    logic [15:0] dig0, dig1;
    logic [3:0]  val0, val1;
    logic        np0, np1, err0, err1;
`ifdef SEVEN_SEG_READER_DP_EN
    logic        dp_in;
    logic [3:0]  dpo0, dpo1;
`endif

    always #5 clk = ~clk;

    seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .sel_in(sel_in),
        .common_cathode(cc), .clr_err(clr_err),
`ifdef SEVEN_SEG_READER_DP_EN
        .dp_in(dp_in), .dp_out(dpo0),
`endif
        .digit_out(dig0), .digit_valid(val0), .new_pulse(np0), .sel_err(err0)
    );

    seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .sel_in(sel_in),
        .common_cathode(cc), .clr_err(clr_err),
`ifdef SEVEN_SEG_READER_DP_EN
        .dp_in(dp_in), .dp_out(dpo1),
`endif
        .digit_out(dig1), .digit_valid(val1), .new_pulse(np1), .sel_err(err1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a commit happens when a one-hot sample has been seen in an
    // unbroken run of exactly S identical enabled samples.
    int unsigned m_S [2];
    int unsigned m_run [2];
    logic [6:0]  m_seg;
    logic [3:0]  m_sel;
    logic [11:0] m_prev;
    logic [15:0] m_dig [2];
    logic [3:0]  m_val [2];
    logic        m_pulse [2];
    logic        m_err;
`ifdef SEVEN_SEG_READER_DP_EN
    logic        m_dp;
    logic [3:0]  m_dpo [2];
`endif

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h3F: return 4'h0;
            7'h06: return 4'h1;
            7'h5B: return 4'h2;
            7'h4F: return 4'h3;
            7'h66: return 4'h4;
            7'h6D: return 4'h5;
            7'h7D: return 4'h6;
            7'h07: return 4'h7;
            7'h7F: return 4'h8;
            7'h6F: return 4'h9;
            7'h49: return 4'hA;
            7'h40: return 4'hB;
            7'h00: return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    task automatic model_edge();
        logic [11:0] key;
        logic [6:0]  pat;
        logic        oh;
        int unsigned idx;
        if (!rst_n) begin
            m_seg = '0; m_sel = '0; m_prev = '0; m_err = 1'b0;
            for (int j = 0; j < 2; j++) begin
                m_run[j] = 0; m_dig[j] = '0; m_val[j] = '0; m_pulse[j] = 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
                m_dpo[j] = '0;
`endif
            end
`ifdef SEVEN_SEG_READER_DP_EN
            m_dp = 1'b0;
`endif
        end else if (!ena) begin
            m_pulse[0] = 1'b0;
            m_pulse[1] = 1'b0;
        end else begin
            pat = cc ? m_seg : ~m_seg;
            key = {m_sel, pat, 1'b0};
`ifdef SEVEN_SEG_READER_DP_EN
            key[0] = cc ? m_dp : ~m_dp;
`endif
            oh  = ($countones(m_sel) == 1);
            idx = 0;
            for (int unsigned b = 0; b < 4; b++) if (m_sel[b]) idx = b;
            for (int j = 0; j < 2; j++) begin
                m_run[j]   = oh ? ((key == m_prev) ? m_run[j] + 1 : 1) : 0;
                m_pulse[j] = oh && (m_run[j] == m_S[j]);
                if (m_pulse[j]) begin
                    m_dig[j][4*idx +: 4] = ref_decode(pat);
                    m_val[j][idx]        = 1'b1;
`ifdef SEVEN_SEG_READER_DP_EN
                    m_dpo[j][idx]        = key[0];
`endif
                end
            end
            if ($countones(m_sel) > 1) m_err = 1'b1;
            else if (clr_err)          m_err = 1'b0;
            m_prev = key;
            m_sel  = sel_in;
            m_seg  = seg_in;
`ifdef SEVEN_SEG_READER_DP_EN
            m_dp   = dp_in;
`endif
        end
    endtask

    task automatic check_model();
        chk("model_digit_s4", 32'(dig0), 32'(m_dig[0]));
        chk("model_valid_s4", 32'(val0), 32'(m_val[0]));
        chk("model_pulse_s4", 32'(np0),  32'(m_pulse[0]));
        chk("model_err_s4",   32'(err0), 32'(m_err));
        chk("model_digit_s1", 32'(dig1), 32'(m_dig[1]));
        chk("model_valid_s1", 32'(val1), 32'(m_val[1]));
        chk("model_pulse_s1", 32'(np1),  32'(m_pulse[1]));
        chk("model_err_s1",   32'(err1), 32'(m_err));
`ifdef SEVEN_SEG_READER_DP_EN
        chk("model_dp_s4", 32'(dpo0), 32'(m_dpo[0]));
        chk("model_dp_s1", 32'(dpo1), 32'(m_dpo[1]));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  seg;
        int unsigned hold;
        logic [15:0] exp_dig;
        logic [3:0]  exp_val;
    } scan_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        scan_t       scan [4];
        logic [6:0]  pats [14];
        int          first, first1, pulses;
        logic [3:0]  s;
        logic [6:0]  p;
        int unsigned hold;

        scan[0] = '{4'b0001, 7'h6D, 6, 16'h0005, 4'b0001};
        scan[1] = '{4'b0010, 7'h07, 6, 16'h0075, 4'b0011};
        scan[2] = '{4'b0100, 7'h49, 6, 16'h0A75, 4'b0111};
        scan[3] = '{4'b1000, 7'h12, 6, 16'hFA75, 4'b1111};
        pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                 7'h07, 7'h7F, 7'h6F, 7'h49, 7'h40, 7'h00, 7'h12};
        m_S[0] = 4;
        m_S[1] = 1;

        rst_n = 1'b0; ena = 1'b1; cc = 1'b0; clr_err = 1'b0;
        seg_in = 7'h7F; sel_in = 4'b0000;
`ifdef SEVEN_SEG_READER_DP_EN
        dp_in = 1'b0;
`endif
        cyc(); cyc();
        chk("reset_digit", 32'(dig0), 32'h0);
        chk("reset_valid", 32'(val0), 32'h0);
        chk("reset_pulse", 32'(np0),  32'h0);
        chk("reset_err",   32'(err0), 32'h0);
        rst_n = 1'b1;

        // Common-anode zero: first pulse 4 edges after the sample edge (1 for S=1).
        sel_in = 4'b0001; seg_in = ~7'h3F;
        first = -1; first1 = -1; pulses = 0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (np0) begin pulses++; if (first < 0) first = k; end
            if (np1 && first1 < 0) first1 = k;
        end
        chk("ca_latency",    32'(first),  32'd4);
        chk("ca_latency_s1", 32'(first1), 32'd1);
        chk("ca_pulses",     32'(pulses), 32'd1);
        chk("ca_code",       32'(dig0[3:0]), 32'h0);
        chk("ca_valid",      32'(val0), 32'b0001);

        // Common-cathode scan across all positions.
        cc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel_in = scan[i].sel; seg_in = scan[i].seg; pulses = 0;
            for (int unsigned k = 0; k < scan[i].hold; k++) begin
                cyc();
                if (np0) pulses++;
            end
            chk("scan_pulses", 32'(pulses), 32'd1);
            chk("scan_digit",  32'(dig0), 32'(scan[i].exp_dig));
            chk("scan_valid",  32'(val0), 32'(scan[i].exp_val));
        end

        // Short glitch followed by a stable pattern: one commit only.
        sel_in = 4'b0010; seg_in = 7'h66; pulses = 0;
        cyc(); if (np0) pulses++;
        cyc(); if (np0) pulses++;
        seg_in = 7'h7F;
        for (int k = 0; k < 6; k++) begin cyc(); if (np0) pulses++; end
        chk("glitch_pulses", 32'(pulses), 32'd1);
        chk("glitch_code",   32'(dig0[7:4]), 32'h8);

        // Multi-hot select: sticky error, no commit, set beats clear.
        sel_in = 4'b0011; pulses = 0;
        cyc(); if (np0) pulses++;
        sel_in = 4'b0000;
        cyc(); if (np0) pulses++;
        cyc(); if (np0) pulses++;
        chk("err_sticky", 32'(err0),   32'd1);
        chk("err_nopulse", 32'(pulses), 32'd0);
        sel_in = 4'b0011;
        cyc();
        sel_in = 4'b0000; clr_err = 1'b1;
        cyc();
        chk("err_set_wins", 32'(err0), 32'd1);
        cyc();
        chk("err_cleared",  32'(err0), 32'd0);
        clr_err = 1'b0;

        // Enable low for three edges mid-settle delays the commit by three.
        sel_in = 4'b0100; seg_in = 7'h7D; first = -1;
        for (int k = 0; k < 11; k++) begin
            ena = !(k >= 2 && k <= 4);
            cyc();
            if (np0 && first < 0) first = k;
        end
        ena = 1'b1;
        chk("ena_delay", 32'(first), 32'd7);
        chk("ena_code",  32'(dig0[11:8]), 32'h6);

        // Reset with the count at 3: nothing commits, everything clears.
        sel_in = 4'b1000; seg_in = 7'h3F; pulses = 0;
        for (int k = 0; k < 4; k++) begin cyc(); if (np0) pulses++; end
        rst_n = 1'b0;
        cyc();
        chk("rst_mid_nopulse", 32'(pulses), 32'd0);
        chk("rst_mid_digit",   32'(dig0),   32'h0);
        chk("rst_mid_valid",   32'(val0),   32'h0);
        chk("rst_mid_pulse",   32'(np0),    32'h0);
        rst_n = 1'b1; sel_in = 4'b0000;
        cyc(); cyc();

        // Polarity flip mid-settle restarts the count.
        sel_in = 4'b0001; seg_in = 7'h06; cc = 1'b1; first = -1;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) cc = 1'b0;
            cyc();
            if (np0 && first < 0) first = k;
        end
        chk("cc_restart", 32'(first), 32'd6);
        chk("cc_code",    32'(dig0[3:0]), 32'hF);
        cc = 1'b1;

`ifdef SEVEN_SEG_READER_DP_EN
        // Toggling dp blocks the commit; a steady dp is captured.
        seg_in = 7'h06; pulses = 0;
        for (int k = 0; k < 6; k++) begin dp_in = k[0]; cyc(); if (np0) pulses++; end
        chk("dp_toggle_nopulse", 32'(pulses), 32'd0);
        dp_in = 1'b1;
        for (int k = 0; k < 6; k++) begin cyc(); if (np0) pulses++; end
        chk("dp_commit_pulses", 32'(pulses), 32'd1);
        chk("dp_captured",      32'(dpo0[0]), 32'd1);
`endif

        // Randomised bursts against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                7:       s = 4'b0000;
                8, 9: begin
                    s = 4'($urandom);
                    if ($countones(s) < 2) s = 4'b1010;
                end
                default: s = 4'(1 << $urandom_range(0, 3));
            endcase
            p = ($urandom_range(0, 4) != 0) ? pats[$urandom_range(0, 13)] : 7'($urandom);
            sel_in = s;
            seg_in = cc ? p : ~p;
            hold   = $urandom_range(1, 7);
            for (int unsigned h = 0; h < hold; h++) begin
                ena     = ($urandom_range(0, 9) != 0);
                clr_err = ($urandom_range(0, 19) == 0);
                rst_n   = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 49) == 0) cc = ~cc;
`ifdef SEVEN_SEG_READER_DP_EN
                if ($urandom_range(0, 5) == 0) dp_in = ~dp_in;
`endif
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
